// File: rtl/wr_beat_gen.sv
// DMA write-side beat generator: splits an unaligned (start_addr, length) request into
// aligned bus-width beats with byte strobes. Optional macro WR_BOUNDARY_CHECK_EN adds err.
module wr_beat_gen #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      start_addr,
    input  logic [LEN_W-1:0]       length,
    output logic                   busy,
    output logic                   done,
    output logic                   beat_valid,
    input  logic                   beat_ready,
    output logic [ADDR_W-1:0]      beat_addr,
    output logic [DATA_W/8-1:0]    beat_strb,
    output logic                   beat_last,
    output logic                   req_data,
`ifdef WR_BOUNDARY_CHECK_EN
    output logic                   err,
`endif
    output logic [1:0]             dbg_state_o
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int CNT_W = LEN_W + 1;

    // Handshake: a beat transfers on any rising edge where beat_valid and beat_ready are both
    // high; beat_addr/strb/last are held unchanged while beat_valid is high and beat_ready low.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic               busy_q;
    logic               done_q;
    logic               valid_q;
    logic               last_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [BYTES-1:0]   strb_q;
    logic [BYTES-1:0]   end_strb_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [ADDR_W-1:0]  end_addr;
    logic [ADDR_W-1:0]  first_a;
    logic [ADDR_W-1:0]  last_a;
    logic [ADDR_W-1:0]  span;
    logic [CNT_W-1:0]   nbeats;
    logic [OFF_W-1:0]   off_s;
    logic [OFF_W-1:0]   off_e;
    logic [BYTES-1:0]   mask_first;
    logic [BYTES-1:0]   mask_last;

    always_comb begin
        end_addr   = start_addr + ADDR_W'(length) - ADDR_W'(1);
        first_a    = {start_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        last_a     = {end_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        span       = last_a - first_a;
        nbeats     = CNT_W'(span >> OFF_W) + CNT_W'(1);
        off_s      = start_addr[OFF_W-1:0];
        off_e      = end_addr[OFF_W-1:0];
        mask_first = {BYTES{1'b1}} << off_s;
        mask_last  = {BYTES{1'b1}} >> (OFF_W'(BYTES - 1) - off_e);
    end

`ifdef WR_BOUNDARY_CHECK_EN
    logic err_q;
    logic cross;
    // A 4 KiB page crossing shows up as a change in the address bits above bit 11.
    assign cross = (start_addr[ADDR_W-1:12] != end_addr[ADDR_W-1:12]);
    assign err   = err_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            addr_q     <= '0;
            strb_q     <= '0;
            end_strb_q <= '0;
            cnt_q      <= '0;
`ifdef WR_BOUNDARY_CHECK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (length == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
`ifdef WR_BOUNDARY_CHECK_EN
                        else if (cross) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end
`endif
                        else begin
                            state_q    <= S_RUN;
                            busy_q     <= 1'b1;
                            valid_q    <= 1'b1;
                            addr_q     <= first_a;
                            end_strb_q <= mask_last;
                            cnt_q      <= nbeats - CNT_W'(1);
                            if (nbeats == CNT_W'(1)) begin
                                strb_q <= mask_first & mask_last;
                                last_q <= 1'b1;
                            end else begin
                                strb_q <= mask_first;
                                last_q <= 1'b0;
                            end
                        end
                    end
                end
                S_RUN: begin
                    if (beat_ready) begin
                        if (last_q) begin
                            state_q <= S_DONE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            // cnt_q counts beats still to come after the current one.
                            addr_q <= addr_q + ADDR_W'(BYTES);
                            cnt_q  <= cnt_q - CNT_W'(1);
                            if (cnt_q == CNT_W'(1)) begin
                                strb_q <= end_strb_q;
                                last_q <= 1'b1;
                            end else begin
                                strb_q <= '1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
`ifdef WR_BOUNDARY_CHECK_EN
                    err_q   <= 1'b0;
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign beat_valid  = valid_q;
    assign beat_addr   = addr_q;
    assign beat_strb   = strb_q;
    assign beat_last   = last_q;
    assign req_data    = valid_q & beat_ready;
    assign dbg_state_o = state_q;

endmodule
